tic_tac_toe_game: RTL and testbench

- Top-level tic-tac-toe engine: a 3x3 board of 2-bit cells, a human player and an externally driven computer opponent that alternate moves.
- Each move is checked for legality, and the board, winner and board-full status are tracked continuously.
- Board cells drive LEDs directly; the computer's move index comes from an external source qualified by `pc`.
- Internally it comprises position registers, a no-space detector, a winner detector and a turn FSM.

---
 rtl/tic_tac_toe_game.sv | 157 +++++++++++++++
 tb/tb_tic_tac_toe_game.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tic_tac_toe_game.sv
// Tic-tac-toe engine: nine 2-bit board cells, win / board-full detection and
// a turn FSM that alternates a human player with an external computer source.
// Optional build macro ILLEGAL_OUT_EN adds the registered illegal_move pulse.
//
// state     | meaning
// ----------|------------------------------------------------------------
// IDLE      | waiting for the player to request a move with play
// PLAYER    | one-cycle slot: write plyr_pos if legal, else back to IDLE
// COMPUTER  | waiting for pc; write comp_pos if legal, retry if illegal
// GAME_OVER | win or full board; frozen until reset
module tic_tac_toe_game #(
  parameter logic [1:0] PLYR_MARK = 2'b01,
  parameter logic [1:0] COMP_MARK = 2'b10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play,
  input  logic       pc,
  input  logic [3:0] comp_pos,
  input  logic [3:0] plyr_pos,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
`ifdef ILLEGAL_OUT_EN
  output logic       illegal_move,
`endif
  output logic [1:0] who
);

  typedef enum logic [1:0] {IDLE, PLAYER, COMPUTER, GAME_OVER} state_t;

  state_t     state, state_nxt;
  logic [1:0] cells [9];
  logic [1:0] line_win [8];
  logic       plyr_free, comp_free, no_space, win;
  logic       wr_en;
  logic [3:0] wr_idx;
  logic [1:0] wr_mark;

  function automatic logic [1:0] line_mark(input logic [1:0] a, input logic [1:0] b,
                                           input logic [1:0] c);
    return (a != 2'b00 && a == b && b == c) ? a : 2'b00;
  endfunction

  assign pos1 = cells[0];
  assign pos2 = cells[1];
  assign pos3 = cells[2];
  assign pos4 = cells[3];
  assign pos5 = cells[4];
  assign pos6 = cells[5];
  assign pos7 = cells[6];
  assign pos8 = cells[7];
  assign pos9 = cells[8];

  assign line_win[0] = line_mark(cells[0], cells[1], cells[2]);
  assign line_win[1] = line_mark(cells[3], cells[4], cells[5]);
  assign line_win[2] = line_mark(cells[6], cells[7], cells[8]);
  assign line_win[3] = line_mark(cells[0], cells[3], cells[6]);
  assign line_win[4] = line_mark(cells[1], cells[4], cells[7]);
  assign line_win[5] = line_mark(cells[2], cells[5], cells[8]);
  assign line_win[6] = line_mark(cells[0], cells[4], cells[8]);
  assign line_win[7] = line_mark(cells[2], cells[4], cells[6]);

  // Winner is the mark of the first complete line; only one mark can ever win.
  always_comb begin
    who = 2'b00;
    for (int k = 0; k < 8; k++) begin
      if (who == 2'b00) who = line_win[k];
    end
  end

  assign win = (who != 2'b00);

  // Target-cell legality and board-full detection; indices 9..15 never match.
  always_comb begin
    plyr_free = 1'b0;
    comp_free = 1'b0;
    no_space  = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (plyr_pos == 4'(k) && cells[k] == 2'b00) plyr_free = 1'b1;
      if (comp_pos == 4'(k) && cells[k] == 2'b00) comp_free = 1'b1;
      if (cells[k] == 2'b00) no_space = 1'b0;
    end
  end

  // Turn FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and the single per-cycle cell write request.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_idx    = 4'd0;
    wr_mark   = 2'b00;
    case (state)
      IDLE: begin
        if (win || no_space) state_nxt = GAME_OVER;
        else if (play)       state_nxt = PLAYER;
      end
      PLAYER: begin
        if (plyr_free) begin
          wr_en     = 1'b1;
          wr_idx    = plyr_pos;
          wr_mark   = PLYR_MARK;
          state_nxt = COMPUTER;
        end else begin
          state_nxt = IDLE;
        end
      end
      COMPUTER: begin
        if (win || no_space) begin
          state_nxt = GAME_OVER;
        end else if (pc && comp_free) begin
          wr_en     = 1'b1;
          wr_idx    = comp_pos;
          wr_mark   = COMP_MARK;
          state_nxt = IDLE;
        end
      end
      GAME_OVER: state_nxt = GAME_OVER;
      default:   state_nxt = IDLE;
    endcase
  end

  // Board cells: written once, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 9; k++) cells[k] <= 2'b00;
    end else if (wr_en) begin
      for (int k = 0; k < 9; k++) begin
        if (wr_idx == 4'(k)) cells[k] <= wr_mark;
      end
    end
  end

`ifdef ILLEGAL_OUT_EN
  logic illegal_now;
  assign illegal_now = (state == PLAYER && !plyr_free) ||
                       (state == COMPUTER && !win && !no_space && pc && !comp_free);

  // One-cycle registered pulse following a rejected move attempt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) illegal_move <= 1'b0;
    else        illegal_move <= illegal_now;
  end
`endif

endmodule

// File: tb/tb_tic_tac_toe_game.sv
// Bench for tic_tac_toe_game: directed vector table, hand-written corner
// sequences, and random play checked against a rule-level game model.
module tb_tic_tac_toe_game;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       play = 1'b0;
  logic       pc = 1'b0;
  logic [3:0] comp_pos = 4'd0;
  logic [3:0] plyr_pos = 4'd0;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, who;
`ifdef ILLEGAL_OUT_EN
  logic       illegal_move;
`endif

  always #5 clk = ~clk;

  tic_tac_toe_game dut (
    .clk(clk), .reset(reset), .play(play), .pc(pc),
    .comp_pos(comp_pos), .plyr_pos(plyr_pos),
    .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
    .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9),
`ifdef ILLEGAL_OUT_EN
    .illegal_move(illegal_move),
`endif
    .who(who)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Rule-level model: board contents plus whose turn it is.
  // phase 0 = awaiting play, 1 = player slot, 2 = computer to move, 3 = over
  logic [1:0] m_board [9];
  int         m_phase;
  logic       m_ill;
  int         lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                               '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic logic [1:0] m_winner();
    for (int l = 0; l < 8; l++) begin
      logic [1:0] a;
      a = m_board[lines[l][0]];
      if (a != 2'b00 && a == m_board[lines[l][1]] && a == m_board[lines[l][2]]) return a;
    end
    return 2'b00;
  endfunction

  function automatic logic m_full();
    for (int k = 0; k < 9; k++) if (m_board[k] == 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 9; k++) m_board[k] = 2'b00;
    m_phase = 0;
    m_ill   = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic pl, input logic p,
                            input logic [3:0] pp, input logic [3:0] cp);
    m_ill = 1'b0;
    if (!r) begin
      model_reset();
    end else begin
      case (m_phase)
        0: if (m_winner() != 2'b00 || m_full()) m_phase = 3;
           else if (pl) m_phase = 1;
        1: if (pp < 4'd9 && m_board[pp] == 2'b00) begin
             m_board[pp] = 2'b01;
             m_phase = 2;
           end else begin
             m_ill = 1'b1;
             m_phase = 0;
           end
        2: if (m_winner() != 2'b00 || m_full()) m_phase = 3;
           else if (p) begin
             if (cp < 4'd9 && m_board[cp] == 2'b00) begin
               m_board[cp] = 2'b10;
               m_phase = 0;
             end else begin
               m_ill = 1'b1;
             end
           end
        default: ;
      endcase
    end
  endtask

  function automatic logic [17:0] dut_board();
    return {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
  endfunction

  function automatic logic [17:0] masks_to_board(input logic [8:0] x, input logic [8:0] o);
    logic [17:0] b;
    b = '0;
    for (int k = 0; k < 9; k++) b[2*k +: 2] = x[k] ? 2'b01 : (o[k] ? 2'b10 : 2'b00);
    return b;
  endfunction

  task automatic check_exp(input string name, input logic [8:0] x, input logic [8:0] o,
                           input logic [1:0] w, input logic ill);
    logic [17:0] e;
    e = masks_to_board(x, o);
    n_vec++;
    if ({dut_board(), who} !== {e, w}) begin
      n_bad++;
      $display("FAIL %s: board=%h who=%b, required board=%h who=%b",
               name, dut_board(), who, e, w);
    end
`ifdef ILLEGAL_OUT_EN
    n_vec++;
    if (illegal_move !== ill) begin
      n_bad++;
      $display("FAIL %s illegal_move: got %b, required %b", name, illegal_move, ill);
    end
`else
    if (ill === 1'bx) $display("note: unknown illegal expectation in %s", name);
`endif
  endtask

  task automatic check_model(input string name);
    logic [17:0] e;
    for (int k = 0; k < 9; k++) e[2*k +: 2] = m_board[k];
    n_vec++;
    if ({dut_board(), who} !== {e, m_winner()}) begin
      n_bad++;
      $display("FAIL %s: board=%h who=%b, required board=%h who=%b",
               name, dut_board(), who, e, m_winner());
    end
`ifdef ILLEGAL_OUT_EN
    n_vec++;
    if (illegal_move !== m_ill) begin
      n_bad++;
      $display("FAIL %s illegal_move: got %b, required %b", name, illegal_move, m_ill);
    end
`endif
  endtask

  // Apply inputs, clock once, advance the model, sample 1 ns after the edge.
  task automatic step(input logic r, input logic pl, input logic p,
                      input logic [3:0] pp, input logic [3:0] cp);
    reset = r; play = pl; pc = p; plyr_pos = pp; comp_pos = cp;
    @(posedge clk);
    #1;
    model_step(r, pl, p, pp, cp);
  endtask

  typedef struct {
    logic       r, pl, p;
    logic [3:0] pp, cp;
    logic [8:0] x, o;
    logic [1:0] w;
    logic       ill;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic pl, input logic p,
                     input logic [3:0] pp, input logic [3:0] cp,
                     input logic [8:0] x, input logic [8:0] o,
                     input logic [1:0] w, input logic ill);
    vec_t v;
    v.r = r; v.pl = pl; v.p = p; v.pp = pp; v.cp = cp;
    v.x = x; v.o = o; v.w = w; v.ill = ill;
    tbl.push_back(v);
  endtask

  logic [3:0] px [5] = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd8};
  logic [3:0] ox [4] = '{4'd2, 4'd3, 4'd4, 4'd7};

  initial begin
    // Win in the top row, then game over.
    add(1'b1,1'b1,1'b0,4'd0,4'd4, 9'b000000000,9'b000000000,2'b00,1'b0);
    add(1'b1,1'b1,1'b0,4'd0,4'd4, 9'b000000001,9'b000000000,2'b00,1'b0);
    add(1'b1,1'b1,1'b0,4'd0,4'd4, 9'b000000001,9'b000000000,2'b00,1'b0);
    add(1'b1,1'b1,1'b0,4'd0,4'd4, 9'b000000001,9'b000000000,2'b00,1'b0);
    add(1'b1,1'b1,1'b0,4'd0,4'd4, 9'b000000001,9'b000000000,2'b00,1'b0);
    add(1'b1,1'b0,1'b1,4'd0,4'd4, 9'b000000001,9'b000010000,2'b00,1'b0);
    add(1'b1,1'b1,1'b0,4'd1,4'd8, 9'b000000001,9'b000010000,2'b00,1'b0);
    add(1'b1,1'b1,1'b0,4'd1,4'd8, 9'b000000011,9'b000010000,2'b00,1'b0);
    add(1'b1,1'b0,1'b1,4'd1,4'd8, 9'b000000011,9'b100010000,2'b00,1'b0);
    add(1'b1,1'b1,1'b0,4'd2,4'd8, 9'b000000011,9'b100010000,2'b00,1'b0);
    add(1'b1,1'b1,1'b0,4'd2,4'd8, 9'b000000111,9'b100010000,2'b01,1'b0);
    add(1'b1,1'b0,1'b1,4'd2,4'd6, 9'b000000111,9'b100010000,2'b01,1'b0);
    add(1'b1,1'b0,1'b1,4'd2,4'd6, 9'b000000111,9'b100010000,2'b01,1'b0);
    add(1'b1,1'b1,1'b0,4'd6,4'd6, 9'b000000111,9'b100010000,2'b01,1'b0);
    // Synchronous view of reset, then illegal-move handling.
    add(1'b0,1'b0,1'b0,4'd0,4'd0, 9'b000000000,9'b000000000,2'b00,1'b0);
    add(1'b1,1'b1,1'b0,4'd4,4'd4, 9'b000000000,9'b000000000,2'b00,1'b0);
    add(1'b1,1'b1,1'b0,4'd4,4'd4, 9'b000010000,9'b000000000,2'b00,1'b0);
    add(1'b1,1'b0,1'b1,4'd4,4'd4, 9'b000010000,9'b000000000,2'b00,1'b1);
    add(1'b1,1'b0,1'b1,4'd4,4'd15,9'b000010000,9'b000000000,2'b00,1'b1);
    add(1'b1,1'b0,1'b1,4'd4,4'd3, 9'b000010000,9'b000001000,2'b00,1'b0);
    add(1'b1,1'b1,1'b0,4'd3,4'd3, 9'b000010000,9'b000001000,2'b00,1'b0);
    add(1'b1,1'b1,1'b0,4'd3,4'd3, 9'b000010000,9'b000001000,2'b00,1'b1);
    add(1'b1,1'b1,1'b0,4'd12,4'd3,9'b000010000,9'b000001000,2'b00,1'b0);
    add(1'b1,1'b1,1'b0,4'd12,4'd3,9'b000010000,9'b000001000,2'b00,1'b1);
    add(1'b1,1'b0,1'b1,4'd12,4'd0,9'b000010000,9'b000001000,2'b00,1'b0);
    add(1'b1,1'b1,1'b0,4'd0,4'd0, 9'b000010000,9'b000001000,2'b00,1'b0);
    add(1'b1,1'b1,1'b0,4'd0,4'd0, 9'b000010001,9'b000001000,2'b00,1'b0);
    add(1'b1,1'b1,1'b0,4'd0,4'd0, 9'b000010001,9'b000001000,2'b00,1'b0);
    add(1'b1,1'b0,1'b1,4'd0,4'd8, 9'b000010001,9'b100001000,2'b00,1'b0);

    model_reset();
    @(posedge clk);
    #1;
    check_exp("reset_state", 9'b0, 9'b0, 2'b00, 1'b0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].pl, tbl[i].p, tbl[i].pp, tbl[i].cp);
      check_exp($sformatf("table_%0d", i), tbl[i].x, tbl[i].o, tbl[i].w, tbl[i].ill);
    end

    // Draw: full board with no line ends the game with no winner.
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, px[i], 4'd0);
      check_model("draw_req");
      step(1'b1, 1'b1, 1'b0, px[i], 4'd0);
      check_model("draw_plyr");
      if (i < 4) begin
        step(1'b1, 1'b0, 1'b1, 4'd0, ox[i]);
        check_model("draw_comp");
      end
    end
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd0);
    check_exp("draw_full", 9'b101100011, 9'b010011100, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 4'd2, 4'd2);
      check_exp("draw_frozen", 9'b101100011, 9'b010011100, 2'b00, 1'b0);
    end

    // Asynchronous reset while waiting for the computer.
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
    check_exp("pre_async", 9'b000000001, 9'b0, 2'b00, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_exp("async_reset", 9'b0, 9'b0, 2'b00, 1'b0);
    model_reset();
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd1);
    check_model("async_hold");
    step(1'b1, 1'b1, 1'b0, 4'd7, 4'd0);
    check_model("post_reset_req");
    step(1'b1, 1'b1, 1'b0, 4'd7, 4'd0);
    check_exp("post_reset_move", 9'b010000000, 9'b0, 2'b00, 1'b0);

    // Random play against the model.
    for (int n = 0; n < 4000; n++) begin
      logic       r, pl, p;
      logic [3:0] pp, cp;
      r  = ($urandom_range(0, 79) != 0);
      pl = $urandom_range(0, 1) == 1;
      p  = $urandom_range(0, 2) != 0;
      pp = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      cp = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      step(r, pl, p, pp, cp);
      check_model("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
